pipeline_if_stage: RTL and testbench
====================================

# pipeline_if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the PC, issues requests to instruction memory under the `MIO_ready` handshake, and drives the IF/ID pipeline register consumed by the ID-stage control decoder. It obeys that decoder's stall and redirect outputs, inserting bubbles and flushing wrong-path fetches. A one-entry skid buffer keeps a returned instruction when ID stalls in the same cycle.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `NOP_INSN`, 32'h0000_0000, encoding placed in IF/ID for bubbles and flushes.
- `clk  in  1  ` single clock; everything samples on the rising edge.
- `rst_n  in  1  ` asynchronous, active-low reset.
- `stall  in  1  ` from ID: data hazard only; hold PC and IF/ID.
- `redirect  in  1  ` from ID: taken jump, jr or branch resolved this cycle.
- `redirect_target  in  32  ` new PC when `redirect`; bits [1:0] are ignored and forced to 0.
- `imem_req  out  1  ` fetch request.
- `imem_addr  out  32  ` equals the current PC.
- `imem_rdata  in  32  ` instruction word; valid only in a cycle with `imem_req && MIO_ready`.
- `MIO_ready  in  1  ` memory completes the request this cycle (combinational response).
- `id_instruction  out  32  ` IF/ID instruction register.
- `id_pc  out  32  ` PC of `id_instruction`.
- `id_pc_plus4  out  32  ` `id_pc + 4`, used as the jal link value.
- `id_valid  out  1  ` 0 for bubbles and flushes.

## Operation
- FSM states:
  - `S_BOOT`: the single cycle after reset release; `imem_req=0`; always goes to `S_FETCH`.
  - `S_FETCH`: `imem_req=1`.
  - `S_HOLD`: `imem_req=0`; the skid buffer is full.
- Priority in each cycle: `stall` first, then `redirect`, then normal fetch. While `stall=1`, `redirect` is ignored (the branch in ID is not yet resolved).
- `S_FETCH`, `MIO_ready=1`, `stall=0`, `redirect=0`:
  - IF/ID loads {`imem_rdata`, PC, valid=1}.
  - `PC<=PC+4`.
- `S_FETCH`, `MIO_ready=1`, `stall=1`:
  - Skid buffer loads {`imem_rdata`, PC}.
  - `PC<=PC+4`; IF/ID holds; next state `S_HOLD`.
- `S_FETCH`, `MIO_ready=0`, `stall=0`: IF/ID loads a bubble (`NOP_INSN`, valid=0); PC holds.
- `S_FETCH`, `MIO_ready=0`, `stall=1`: PC and IF/ID hold.
- `S_HOLD`, `stall=1`: everything holds.
- `S_HOLD`, `stall=0`, `redirect=0`: IF/ID loads the skid entry (valid=1); skid empties; next state `S_FETCH`.
- `redirect=1` (with `stall=0`), in `S_FETCH` or `S_HOLD`:
  - `PC<={redirect_target[31:2],2'b00}`.
  - IF/ID is flushed (NOP, valid=0).
  - The skid entry and any same-cycle `imem_rdata` are discarded.
  - Next state `S_FETCH`.
- `redirect=1` in `S_BOOT`: ignored.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values (asynchronous): PC=`RESET_PC`; state `S_BOOT`; `imem_req=0`; `imem_addr=RESET_PC`; `id_instruction=NOP_INSN`; `id_pc=0`; `id_pc_plus4=4`; `id_valid=0`; skid buffer empty.
- Fetch latency: a word accepted at edge n appears on the `id_*` outputs after edge n, i.e. in cycle n+1.
- Back-to-back throughput: one instruction per cycle while `MIO_ready=1` and no stall or redirect.
- Redirect latency: `redirect` in cycle n gives `imem_addr=target` and `id_valid=0` in cycle n+1. A one-bubble penalty beyond the ID resolve point.
- Reset asserted mid-fetch or in `S_HOLD`: the in-flight word and skid entry are lost; the block restarts from `S_BOOT`.
- `imem_addr` is stable whenever `imem_req=1` and `MIO_ready=0`.

## Structure
- Shared package `pipeline_pkg`:
  - `NOP_INSN` constant.
  - `if_state_t` enum {`S_BOOT`, `S_FETCH`, `S_HOLD`}.
  - Default `RESET_PC`.
- Sub-module `if_skid_buffer`: one-entry {insn, pc} register with a full flag, plus load, drain and flush controls.
- PC register, FSM and IF/ID register live in the top level.

## Test plan
- Reset, then `MIO_ready=1` constant, words 0x20080001, 0x20090002, 0x200A0003:
  - cycle 1 has `imem_req=0`;
  - afterwards `id_pc` reads 0, 4, 8 on consecutive cycles, each with `id_valid=1`.
- `stall` held for 3 cycles while `MIO_ready=1`:
  - the word at PC 8 goes to the skid buffer and `imem_req` drops;
  - on release, `id_pc=8` appears next cycle with no duplicate and no loss.
- `redirect=1`, target 0x0000_0041, while a word at PC 0xC returns: PC becomes 0x40, the word is discarded, `id_valid=0` for one cycle, then `id_pc=0x40`.
- `stall=1` and `redirect=1` together for 2 cycles, then redirect alone: PC changes only after stall drops.
- `MIO_ready` alternating 0/1: on each 0-cycle a bubble appears (`id_valid=0`, NOP); the PC sequence advances by 4 only on accepted words.
- `rst_n` pulled low in `S_HOLD`: outputs take their reset values immediately, and fetch restarts at `RESET_PC` after `S_BOOT`.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared definitions for the MIPS pipeline stages: bubble encoding, reset PC
// and the instruction-fetch FSM state type.
package pipeline_pkg;

   localparam logic [31:0] NOP_INSN         = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } if_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {insn, pc} holding register that catches a fetched word when ID
// stalls in the cycle the memory answers.
module if_skid_buffer
   import pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        drain,
   input  logic        flush,
   input  logic [31:0] load_insn,
   input  logic [31:0] load_pc,
   output logic        full,
   output logic [31:0] insn,
   output logic [31:0] pc
);

   logic        full_q, full_d;
   logic [31:0] insn_q, insn_d;
   logic [31:0] pc_q,   pc_d;

   always_comb begin
      full_d = full_q;
      insn_d = insn_q;
      pc_d   = pc_q;
      if (flush) begin
         full_d = 1'b0;
      end else if (load) begin
         full_d = 1'b1;
         insn_d = load_insn;
         pc_d   = load_pc;
      end else if (drain) begin
         full_d = 1'b0;
      end
   end

   // NOTE: the payload is reset as well as the flag; it is a single entry, and a
   // known value keeps X out of ID if the flag is ever mis-sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         insn_q <= NOP_INSN;
         pc_q   <= '0;
      end else begin
         full_q <= full_d;
         insn_q <= insn_d;
         pc_q   <= pc_d;
      end
   end

   assign full = full_q;
   assign insn = insn_q;
   assign pc   = pc_q;

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: PC register, fetch FSM and IF/ID register. Obeys the
// ID decoder's stall and redirect, with a skid buffer for same-cycle stalls.
module pipeline_if_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        MIO_ready,
   output logic [31:0] id_instruction,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic        id_valid
);

   if_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_instruction_q, id_instruction_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic        id_valid_q, id_valid_d;

   logic        skid_load, skid_drain, skid_flush, skid_full;
   logic [31:0] skid_insn, skid_pc;

   if_skid_buffer u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (skid_load),
      .drain     (skid_drain),
      .flush     (skid_flush),
      .load_insn (imem_rdata),
      .load_pc   (pc_q),
      .full      (skid_full),
      .insn      (skid_insn),
      .pc        (skid_pc)
   );

   // NOTE: every output of this block gets a hold value first, so no path
   // through the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      id_instruction_d = id_instruction_q;
      id_pc_d          = id_pc_q;
      id_valid_d       = id_valid_q;
      skid_load        = 1'b0;
      skid_drain       = 1'b0;
      skid_flush       = 1'b0;

      case (state_q)
         S_BOOT: state_d = S_FETCH;

         S_FETCH: begin
            if (stall) begin
               if (MIO_ready) begin
                  skid_load = 1'b1;
                  pc_d      = pc_q + 32'd4;
                  state_d   = S_HOLD;
               end
            end else if (redirect) begin
               pc_d             = word_align(redirect_target);
               id_instruction_d = NOP_INSN;
               id_valid_d       = 1'b0;
               skid_flush       = 1'b1;
            end else if (MIO_ready) begin
               id_instruction_d = imem_rdata;
               id_pc_d          = pc_q;
               id_valid_d       = 1'b1;
               pc_d             = pc_q + 32'd4;
            end else begin
               id_instruction_d = NOP_INSN;
               id_valid_d       = 1'b0;
            end
         end

         S_HOLD: begin
            // PC already points past the buffered word, so draining leaves it alone.
            if (!stall) begin
               state_d = S_FETCH;
               if (redirect) begin
                  pc_d             = word_align(redirect_target);
                  id_instruction_d = NOP_INSN;
                  id_valid_d       = 1'b0;
                  skid_flush       = 1'b1;
               end else if (skid_full) begin
                  id_instruction_d = skid_insn;
                  id_pc_d          = skid_pc;
                  id_valid_d       = 1'b1;
                  skid_drain       = 1'b1;
               end
            end
         end

         default: state_d = S_BOOT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_BOOT;
         pc_q             <= RESET_PC;
         id_instruction_q <= NOP_INSN;
         id_pc_q          <= '0;
         id_valid_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         id_instruction_q <= id_instruction_d;
         id_pc_q          <= id_pc_d;
         id_valid_q       <= id_valid_d;
      end
   end

   assign imem_req       = (state_q == S_FETCH);
   assign imem_addr      = pc_q;
   assign id_instruction = id_instruction_q;
   assign id_pc          = id_pc_q;
   assign id_pc_plus4    = id_pc_q + 32'd4;
   assign id_valid       = id_valid_q;

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Self-checking bench for pipeline_if_stage: per-cycle vector tables plus a
// delivery scoreboard that catches lost or duplicated instructions.
module tb_pipeline_if_stage;

   typedef struct {
      logic        st;
      logic        rd;
      logic [31:0] tgt;
      logic        rdy;
      logic        acc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_target = '0;
   logic        mio_ready = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] id_instruction;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   logic        id_valid;

   int          checks = 0;
   int          errors = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] exp_q[$];
   vec_t        tbl1[$];
   vec_t        tbl2[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] insn_for(input logic [31:0] a);
      return 32'h2008_0001 + (a >> 2) * 32'h0001_0001;
   endfunction

   assign imem_rdata = mio_ready ? insn_for(imem_addr) : 32'hDEAD_BEEF;

   pipeline_if_stage dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .MIO_ready       (mio_ready),
      .id_instruction  (id_instruction),
      .id_pc           (id_pc),
      .id_pc_plus4     (id_pc_plus4),
      .id_valid        (id_valid)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] tgt,
                               input logic rdy, input logic acc, input logic e_req,
                               input logic [31:0] e_addr, input logic e_valid,
                               input logic [31:0] e_pc);
      vec_t v;
      v.st = st; v.rd = rd; v.tgt = tgt; v.rdy = rdy; v.acc = acc;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
      return v;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, ".imem_req"},  {31'b0, imem_req}, 32'd0);
      check({tag, ".imem_addr"}, imem_addr, 32'h0);
      check({tag, ".id_insn"},   id_instruction, 32'h0);
      check({tag, ".id_pc"},     id_pc, 32'h0);
      check({tag, ".id_pc4"},    id_pc_plus4, 32'h4);
      check({tag, ".id_valid"},  {31'b0, id_valid}, 32'd0);
   endtask

   // Drive one cycle's inputs, check the cycle's outputs mid-cycle, then advance.
   task automatic run_vec(input string tag, input vec_t t);
      logic [31:0] exp_pc;
      stall           = t.st;
      redirect        = t.rd;
      redirect_target = t.tgt;
      mio_ready       = t.rdy;
      if (t.acc) exp_q.push_back(t.e_addr);
      @(negedge clk);
      check({tag, ".imem_req"},  {31'b0, imem_req}, {31'b0, t.e_req});
      check({tag, ".imem_addr"}, imem_addr, t.e_addr);
      check({tag, ".id_valid"},  {31'b0, id_valid}, {31'b0, t.e_valid});
      if (t.e_valid) begin
         check({tag, ".id_pc"},   id_pc, t.e_pc);
         check({tag, ".id_pc4"},  id_pc_plus4, t.e_pc + 32'd4);
         check({tag, ".id_insn"}, id_instruction, insn_for(t.e_pc));
      end else begin
         check({tag, ".id_insn"}, id_instruction, 32'h0);
      end
      // A valid IF/ID that was not held last cycle is a fresh delivery.
      if (id_valid && !prev_stall) begin
         if (exp_q.size() == 0) begin
            check({tag, ".unexpected_delivery"}, id_pc, 32'hFFFF_FFFF);
         end else begin
            exp_pc = exp_q.pop_front();
            check({tag, ".sb_pc"},   id_pc, exp_pc);
            check({tag, ".sb_insn"}, id_instruction, insn_for(exp_pc));
         end
      end
      prev_stall = t.st;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //            st rd tgt           rdy acc req addr          val pc
      tbl1.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h0));
      tbl1.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0,        0, 32'h0));
      tbl1.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h4,        1, 32'h0));
      tbl1.push_back(mk(1, 0, 32'h0,        1, 1, 1, 32'h8,        1, 32'h4));
      tbl1.push_back(mk(1, 0, 32'h0,        1, 0, 0, 32'hC,        1, 32'h4));
      tbl1.push_back(mk(1, 0, 32'h0,        1, 0, 0, 32'hC,        1, 32'h4));
      tbl1.push_back(mk(0, 0, 32'h0,        1, 0, 0, 32'hC,        1, 32'h4));
      tbl1.push_back(mk(0, 1, 32'h41,       1, 0, 1, 32'hC,        1, 32'h8));
      tbl1.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h40,       0, 32'h0));
      tbl1.push_back(mk(1, 1, 32'h100,      0, 0, 1, 32'h44,       1, 32'h40));
      tbl1.push_back(mk(1, 1, 32'h100,      0, 0, 1, 32'h44,       1, 32'h40));
      tbl1.push_back(mk(0, 1, 32'h100,      1, 0, 1, 32'h44,       1, 32'h40));
      tbl1.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h100,      0, 32'h0));
      tbl1.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h100,      0, 32'h0));
      tbl1.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h104,      1, 32'h100));
      tbl1.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h104,      0, 32'h0));
      tbl1.push_back(mk(0, 0, 32'h0,        0, 0, 1, 32'h108,      1, 32'h104));
      tbl1.push_back(mk(1, 0, 32'h0,        1, 0, 1, 32'h108,      0, 32'h0));
      tbl1.push_back(mk(0, 1, 32'h200,      0, 0, 0, 32'h10C,      0, 32'h0));
      tbl1.push_back(mk(1, 0, 32'h0,        1, 0, 1, 32'h200,      0, 32'h0));
      tbl1.push_back(mk(1, 0, 32'h0,        1, 0, 0, 32'h204,      0, 32'h0));

      tbl2.push_back(mk(0, 1, 32'h80,       1, 0, 0, 32'h0,        0, 32'h0));
      tbl2.push_back(mk(0, 1, 32'hFFFF_FFFF,1, 0, 1, 32'h0,        0, 32'h0));
      tbl2.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0));
      tbl2.push_back(mk(0, 0, 32'h0,        1, 1, 1, 32'h0,        1, 32'hFFFF_FFFC));
      tbl2.push_back(mk(0, 0, 32'h0,        1, 0, 1, 32'h4,        1, 32'h0));

      // Power-on reset.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("por");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      for (int i = 0; i < tbl1.size(); i++)
         run_vec($sformatf("t1[%0d]", i), tbl1[i]);

      // Still stalled in S_HOLD: pull reset asynchronously mid-cycle.
      stall = 1'b1;
      #2;
      check("hold.imem_req", {31'b0, imem_req}, 32'd0);
      check("hold.imem_addr", imem_addr, 32'h204);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      exp_q.delete();
      prev_stall = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("rst_held");
      rst_n = 1'b1;

      for (int i = 0; i < tbl2.size(); i++)
         run_vec($sformatf("t2[%0d]", i), tbl2[i]);

      check("sb_leftover", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
